myproject_mul_pipe_ss: RTL and testbench
========================================

// Module: myproject_mul_pipe_ss
// PURPOSE
//  Pipelined signed x signed multiplier with valid/ready flow control, arithmetic rescale and
//  optional saturation. Successor to the single-cycle combinational multipliers in the generated
//  datapath. Used in the dense/VAE layers where products must be registered, rescaled to the
//  ap_fixed output format and stalled by downstream back-pressure.
// PARAMETERS
//  ID          1   instance tag; no functional effect
//  NUM_STAGE   3   register stages from input acceptance to dout; legal range 1..8
//  din0_WIDTH  32  signed operand A width
//  din1_WIDTH  18  signed operand B width
//  dout_WIDTH  48  result width; legal when dout_WIDTH <= din0_WIDTH+din1_WIDTH-SHIFT
//  SHIFT       0   arithmetic right shift applied to the full product (fixed-point rescale)
// PORTS
//  clk        in   1            clock; all state updates on the rising edge
//  reset      in   1            asynchronous, active-high reset
//  ce         in   1            clock enable; when 0, all state freezes
//  in_valid   in   1            din0/din1 hold a valid operand pair
//  in_ready   out  1            block accepts the pair this cycle
//  din0       in   din0_WIDTH   operand A, two's complement
//  din1       in   din1_WIDTH   operand B, two's complement
//  out_valid  out  1            dout holds a valid result
//  out_ready  in   1            consumer takes dout this cycle
//  dout       out  dout_WIDTH   result, two's complement
//  ovf        out  1            sticky overflow flag; behaviour set by MUL_SAT_EN
// BEHAVIOUR
//  - Reset (async assert): all stage valid bits, data registers, dout and ovf clear to 0;
//    out_valid=0. in_ready follows its equation, so in_ready=ce while reset is held.
//    Reset asserted mid-operation drops all in-flight results; nothing is emitted afterwards.
//  - Arithmetic: P = $signed(din0)*$signed(din1), full width din0_WIDTH+din1_WIDTH.
//    S = P >>> SHIFT (floor rounding, AP_TRN). R = S reduced to dout_WIDTH (see CONFIGURATION).
//  - Pipeline: NUM_STAGE stages, each with a data register and a valid bit v[k].
//    advance = ce && (out_ready || !v[NUM_STAGE-1]). in_ready = advance (combinational).
//  - When advance=1, every stage shifts forward in one step and v[0] <= in_valid.
//    When advance=0, no stage changes, including bubbles. Bubbles are not collapsed.
//  - Latency is NUM_STAGE cycles from the accept edge to out_valid with no stall.
//    Throughput is 1 result per cycle.
//  - dout and out_valid come from the last stage. Once out_valid=1, dout stays stable until
//    the out_valid && out_ready && ce handshake completes.
//  - ce=0 overrides everything: no accept, no emit, dout held. This applies even with
//    out_ready=1.
//  - Simultaneous accept and emit in the same cycle is legal. Occupancy is unchanged and no
//    data is lost.
//  - Retiming of the multiply across stages (for example an input register ahead of the DSP)
//    is permitted. Port-level behaviour must match the description above exactly.
// CONFIGURATION
//  MUL_SAT_EN defined:
//    - If S is outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1], R clamps to that bound.
//    - ovf sets on the emit handshake of a clamped result and stays set until reset.
//  MUL_SAT_EN undefined:
//    - R = S[dout_WIDTH-1:0] (two's-complement wrap). ovf is tied to 0.
//    - No saturation logic is generated.
//  The per-stage overflow marker travels with its data and is present only with MUL_SAT_EN.
// STRUCTURE
//  Shared package myproject_mul_pkg holds:
//    - localparam function prod_w(a,b) = a+b
//    - function sat_s(value, width), the signed clamp
//    - the NUM_STAGE legal-range check constants
//  Sub-module myproject_pipe_ctrl #(NUM_STAGE) holds the valid-bit chain, advance and in_ready.
//  It is datapath-free and reusable by future pipelined adders.
//  The top level instantiates pipe_ctrl plus the data/ovf register array gated by advance.
// TESTING
//  1. NUM_STAGE=3, SHIFT=0, wrap. Stream A=-3,B=5 / A=2^31-1,B=2 / A=-2^31,B=-2^17,
//     out_ready=1 -> dout=-15, 2^32-2, 2^48 mod 2^48 (=0 at 48b) on cycles 3,4,5.
//  2. SHIFT=4: A=-1,B=1 -> dout=-1 (floor). A=31,B=1 -> dout=1.
//  3. Back-pressure: feed 5 pairs, hold out_ready=0 for 6 cycles.
//     -> in_ready drops once 3 are in flight; dout holds the first result;
//     after release all 5 emerge in order with no loss or duplication.
//  4. ce=0 pulse for 2 cycles mid-stream -> the valid pattern and dout freeze and resume;
//     order is preserved.
//  5. MUL_SAT_EN, dout_WIDTH=16: A=300,B=200 -> dout=32767, ovf=1 sticky.
//     A=-300,B=200 -> dout=-32768.
//     Without the macro, the same inputs give dout=60000 mod 2^16 as signed, and ovf=0.
//  6. Assert reset with 3 results in flight -> out_valid=0 and dout=0 immediately;
//     after release no stale result appears.

Source files
------------

// File: rtl/myproject_mul_pkg.sv
// Shared definitions for the pipelined multiplier family: width helper,
// signed clamp and the legal NUM_STAGE range.
package myproject_mul_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 8;

    // Working width for the clamp; must cover the widest full product.
    localparam int SAT_W = 128;

    function automatic int prod_w(input int a, input int b);
        return a + b;
    endfunction

    // Clamp a signed value into [-2^(width-1), 2^(width-1)-1].
    function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] value,
                                                      input int width);
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] hi;
        lo = {SAT_W{1'b1}} << (width - 1);
        hi = ~lo;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/myproject_mul_pipe_ss_if.sv
// Operand/result handshake bundle for myproject_mul_pipe_ss.
// master = producer/consumer side, slave = the multiplier.
interface myproject_mul_pipe_ss_if #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 48
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [din0_WIDTH-1:0] din0;
    logic signed [din1_WIDTH-1:0] din1;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [dout_WIDTH-1:0] dout;
    logic                         ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/myproject_pipe_ctrl.sv
// Datapath-free valid-bit chain for an N-stage stallable pipeline.
// Produces the shared advance strobe, in_ready and out_valid.
module myproject_pipe_ctrl #(
    parameter int NUM_STAGE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic in_valid,
    input  logic out_ready,
    output logic advance,
    output logic in_ready,
    output logic out_valid
);

    logic [NUM_STAGE-1:0] v;

    // The whole pipe moves as one; bubbles are kept rather than collapsed.
    assign advance   = ce && (out_ready || !v[NUM_STAGE-1]);
    assign in_ready  = advance;
    assign out_valid = v[NUM_STAGE-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
        end else if (advance) begin
            // NOTE: non-blocking, so each v[k-1] read here is the pre-edge value
            // and the loop order cannot turn the shift into a ripple-through.
            v[0] <= in_valid;
            for (int k = 1; k < NUM_STAGE; k++)
                v[k] <= v[k-1];
        end
    end

endmodule

// File: rtl/myproject_mul_pipe_ss.sv
// Pipelined signed x signed multiplier with valid/ready flow control and rescale.
// Optional saturation and sticky overflow flag when MUL_SAT_EN is defined.
module myproject_mul_pipe_ss
    import myproject_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 48,
    parameter int SHIFT      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    myproject_mul_pipe_ss_if.slave  bus
);

    localparam int PW = prod_w(din0_WIDTH, din1_WIDTH);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
        $error("myproject_mul_pipe_ss: NUM_STAGE out of range");
    end

    logic advance;
    logic in_ready;
    logic out_valid;

    myproject_pipe_ctrl #(.NUM_STAGE(NUM_STAGE)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .advance   (advance),
        .in_ready  (in_ready),
        .out_valid (out_valid)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;

    // The product is formed ahead of stage 0; stage registers carry the
    // already-reduced result so only dout_WIDTH bits travel down the pipe.
    logic signed [PW-1:0]         a_ext;
    logic signed [PW-1:0]         b_ext;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         scaled;
    logic signed [dout_WIDTH-1:0] r;

    assign a_ext  = PW'(bus.din0);
    assign b_ext  = PW'(bus.din1);
    assign prod   = a_ext * b_ext;
    assign scaled = prod >>> SHIFT;

    logic signed [dout_WIDTH-1:0] data [NUM_STAGE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data array is reset on purpose -- dout must read 0
            // immediately on reset, so these cannot be left as plain storage.
            for (int k = 0; k < NUM_STAGE; k++)
                data[k] <= '0;
        end else if (advance) begin
            data[0] <= r;
            for (int k = 1; k < NUM_STAGE; k++)
                data[k] <= data[k-1];
        end
    end

    assign bus.dout = data[NUM_STAGE-1];

`ifdef MUL_SAT_EN
    logic signed [SAT_W-1:0] s_ext;
    logic signed [SAT_W-1:0] s_clamp;
    logic                    r_sat;
    logic [NUM_STAGE-1:0]    sat_q;
    logic                    ovf_q;

    assign s_ext   = SAT_W'(scaled);
    assign s_clamp = sat_s(s_ext, dout_WIDTH);
    assign r       = s_clamp[dout_WIDTH-1:0];
    assign r_sat   = (s_clamp != s_ext);

    // Clamp marker rides alongside its result so ovf fires only when that
    // result is actually handed to the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (advance) begin
                sat_q[0] <= r_sat;
                for (int k = 1; k < NUM_STAGE; k++)
                    sat_q[k] <= sat_q[k-1];
            end
            if (ce && out_valid && bus.out_ready && sat_q[NUM_STAGE-1])
                ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_hi;

    assign r = scaled[dout_WIDTH-1:0];

    if (dout_WIDTH < PW) begin : g_drop_hi
        assign unused_hi = ^scaled[PW-1:dout_WIDTH];
    end else begin : g_no_hi
        assign unused_hi = 1'b0;
    end

    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_myproject_mul_pipe_ss.sv
// Directed bench for myproject_mul_pipe_ss: latency, rescale, back-pressure,
// ce freeze, saturation/wrap and mid-flight reset.
module tb_myproject_mul_pipe_ss;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    always #5 clk = ~clk;

    myproject_mul_pipe_ss_if #(.din0_WIDTH(32), .din1_WIDTH(18), .dout_WIDTH(48)) m ();
    myproject_mul_pipe_ss_if #(.din0_WIDTH(32), .din1_WIDTH(18), .dout_WIDTH(48)) s ();
    myproject_mul_pipe_ss_if #(.din0_WIDTH(32), .din1_WIDTH(18), .dout_WIDTH(16)) n ();

    myproject_mul_pipe_ss #(.NUM_STAGE(3), .dout_WIDTH(48), .SHIFT(0)) u_main (
        .clk(clk), .reset(reset), .ce(ce), .bus(m));
    myproject_mul_pipe_ss #(.NUM_STAGE(3), .dout_WIDTH(48), .SHIFT(4)) u_shift (
        .clk(clk), .reset(reset), .ce(ce), .bus(s));
    myproject_mul_pipe_ss #(.NUM_STAGE(3), .dout_WIDTH(16), .SHIFT(0)) u_narrow (
        .clk(clk), .reset(reset), .ce(ce), .bus(n));

    typedef struct {
        logic signed [31:0] a;
        logic signed [17:0] b;
        logic signed [47:0] e;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int emit_cnt = 0;
    logic signed [47:0] exp_q [$];

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard bookkeeping for the main instance, then one clock.
    task automatic step(input logic signed [47:0] e, output logic acc);
        acc = m.in_valid && m.in_ready;
        if (acc)
            exp_q.push_back(e);
        if (ce && m.out_valid && m.out_ready) begin
            emit_cnt++;
            check("emit_has_exp", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
                check("dout", m.dout, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    vec_t t1 [3];
    vec_t t3 [5];
    vec_t t4 [4];
    vec_t ts [3];
    vec_t tn [3];
    logic acc;
    int   k;
    int   cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        t1[0] = '{a: -32'sd3,          b: 18'sd5,       e: -48'sd15};
        t1[1] = '{a: 32'sh7FFF_FFFF,   b: 18'sd2,       e: 48'sd4294967294};
`ifdef MUL_SAT_EN
        t1[2] = '{a: 32'sh8000_0000,   b: 18'sh20000,   e: 48'sh7FFF_FFFF_FFFF};
`else
        t1[2] = '{a: 32'sh8000_0000,   b: 18'sh20000,   e: 48'sd0};
`endif
        t3[0] = '{a: 32'sd7,     b: 18'sd6,    e: 48'sd42};
        t3[1] = '{a: -32'sd8,    b: 18'sd9,    e: -48'sd72};
        t3[2] = '{a: 32'sd100,   b: -18'sd100, e: -48'sd10000};
        t3[3] = '{a: -32'sd1,    b: -18'sd1,   e: 48'sd1};
        t3[4] = '{a: 32'sd12345, b: 18'sd3,    e: 48'sd37035};
        t4[0] = '{a: 32'sd1,     b: 18'sd1,    e: 48'sd1};
        t4[1] = '{a: 32'sd2,     b: -18'sd3,   e: -48'sd6};
        t4[2] = '{a: -32'sd4,    b: -18'sd5,   e: 48'sd20};
        t4[3] = '{a: 32'sd1000,  b: 18'sd1000, e: 48'sd1000000};
        ts[0] = '{a: -32'sd1,    b: 18'sd1,    e: -48'sd1};
        ts[1] = '{a: 32'sd31,    b: 18'sd1,    e: 48'sd1};
        ts[2] = '{a: -32'sd17,   b: 18'sd1,    e: -48'sd2};
        tn[0] = '{a: 32'sd100,   b: 18'sd100,  e: 48'sd10000};
`ifdef MUL_SAT_EN
        tn[1] = '{a: 32'sd300,   b: 18'sd200,  e: 48'sd32767};
        tn[2] = '{a: -32'sd300,  b: 18'sd200,  e: -48'sd32768};
`else
        tn[1] = '{a: 32'sd300,   b: 18'sd200,  e: -48'sd5536};
        tn[2] = '{a: -32'sd300,  b: 18'sd200,  e: 48'sd5536};
`endif

        reset = 1'b1;
        ce    = 1'b1;
        m.in_valid = 1'b0; m.din0 = '0; m.din1 = '0; m.out_ready = 1'b1;
        s.in_valid = 1'b0; s.din0 = '0; s.din1 = '0; s.out_ready = 1'b1;
        n.in_valid = 1'b0; n.din0 = '0; n.din1 = '0; n.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", m.out_valid, 0);
        check("rst_dout", m.dout, 0);
        check("rst_in_ready", m.in_ready, 1);
        check("rst_ovf", n.ovf, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Streaming, three-cycle latency, wrap at full width
        for (int i = 0; i < 3; i++) begin
            m.in_valid = 1'b1; m.din0 = t1[i].a; m.din1 = t1[i].b; m.out_ready = 1'b1;
            #1;
            check("lat_no_valid", m.out_valid, 0);
            step(t1[i].e, acc);
        end
        m.in_valid = 1'b0;
        #1;
        check("lat_valid_c3", m.out_valid, 1);
        for (int i = 0; i < 3; i++)
            step(48'sd0, acc);
        check("t1_idle", m.out_valid, 0);
        check("t1_drained", exp_q.size(), 0);

        // Back-pressure: consumer blocked for six cycles
        k = 0; cyc = 0; emit_cnt = 0;
        while ((k < 5 || exp_q.size() > 0) && cyc < 40) begin
            m.out_ready = (cyc >= 6);
            m.in_valid  = (k < 5);
            if (k < 5) begin
                m.din0 = t3[k].a;
                m.din1 = t3[k].b;
            end
            #1;
            if (cyc == 3 || cyc == 5) begin
                check("bp_in_ready", m.in_ready, 0);
                check("bp_hold_valid", m.out_valid, 1);
                check("bp_hold_dout", m.dout, t3[0].e);
            end
            step((k < 5) ? t3[k].e : 48'sd0, acc);
            if (acc)
                k++;
            cyc++;
        end
        check("bp_emits", emit_cnt, 5);
        check("bp_drained", exp_q.size(), 0);

        // Two-cycle ce pause mid-stream
        k = 0; cyc = 0; emit_cnt = 0;
        m.out_ready = 1'b1;
        while ((k < 4 || exp_q.size() > 0) && cyc < 30) begin
            ce = !(cyc == 3 || cyc == 4);
            m.in_valid = (k < 4);
            if (k < 4) begin
                m.din0 = t4[k].a;
                m.din1 = t4[k].b;
            end
            #1;
            if (cyc == 3)
                check("ce_in_ready", m.in_ready, 0);
            if (cyc >= 3 && cyc <= 5) begin
                check("ce_hold_valid", m.out_valid, 1);
                check("ce_hold_dout", m.dout, t4[0].e);
            end
            step((k < 4) ? t4[k].e : 48'sd0, acc);
            if (acc)
                k++;
            cyc++;
        end
        ce = 1'b1;
        check("ce_emits", emit_cnt, 4);
        check("ce_drained", exp_q.size(), 0);
        m.in_valid = 1'b0;

        // Rescale floor and saturation/wrap on the side instances
        for (int c = 0; c < 8; c++) begin
            s.in_valid = (c < 3);
            n.in_valid = (c < 3);
            if (c < 3) begin
                s.din0 = ts[c].a; s.din1 = ts[c].b;
                n.din0 = tn[c].a; n.din1 = tn[c].b;
            end
            @(posedge clk);
            #1;
            if (c + 1 >= 3 && c + 1 <= 5) begin
                check("shift_valid", s.out_valid, 1);
                check("shift_dout", s.dout, ts[c-2].e);
                check("narrow_valid", n.out_valid, 1);
                check("narrow_dout", n.dout, tn[c-2].e);
            end
            if (c + 1 == 4)
                check("ovf_before", n.ovf, 0);
            if (c + 1 == 5 || c + 1 == 7) begin
`ifdef MUL_SAT_EN
                check("ovf_sticky", n.ovf, 1);
`else
                check("ovf_tied", n.ovf, 0);
`endif
            end
            if (c + 1 == 7)
                check("shift_idle", s.out_valid, 0);
        end
        s.in_valid = 1'b0;
        n.in_valid = 1'b0;

        // Reset with three results in flight
        m.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m.in_valid = 1'b1; m.din0 = t3[i].a; m.din1 = t3[i].b;
            #1;
            step(t3[i].e, acc);
        end
        m.in_valid = 1'b0;
        #1;
        check("pre_rst_valid", m.out_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_flight_valid", m.out_valid, 0);
        check("rst_flight_dout", m.dout, 0);
        exp_q.delete();
        #1;
        reset = 1'b0;
        m.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("post_rst_quiet", m.out_valid, 0);
            step(48'sd0, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
